riscv_alu: RTL and testbench
============================

Name: riscv_alu

Overview:
- 64-bit integer ALU for the RV64I execute stage; operands come from the register file/immediate mux, control from the ALU-control decoder.
- Computes one of 16 operations selected by a 4-bit code.
- Registers the result and a zero flag; the registered flag is used for branch resolution in the next cycle.

Parameters:
- None. Datapath width is fixed at 64 bits; W-ops operate on the low 32 bits.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- ALUctl  input  4  operation select.
- A  input  64  operand 1 (rs1).
- B  input  64  operand 2 (rs2 or immediate).
- ALUout  output  64  registered result.
- Zero  output  1  registered flag; 1 exactly when ALUout == 0.

Behaviour:
- Reset: on rst_n low, ALUout = 0 and Zero = 1 immediately, independent of clk. Both hold while rst_n is low. The first capture happens at the first rising clk after rst_n deasserts.
- Latency: 1 cycle. Inputs are sampled at rising clk; ALUout and Zero update together. No enable and no handshake; a new operation can start every cycle.
- Zero is computed from the same next-state result as ALUout, so it never lags ALUout.
- Opcode map (all arithmetic is modulo 2^64 with no overflow or carry outputs):
  - 0 AND: A & B
  - 1 OR: A | B
  - 2 ADD: A + B
  - 3 XOR: A ^ B
  - 4 SLL: A << B[5:0]
  - 5 SRL: A >> B[5:0], logical
  - 6 SUB: A - B
  - 7 SLT: signed A < B ? 1 : 0, zero-extended to 64 bits
  - 8 SLTU: unsigned A < B ? 1 : 0
  - 9 SRA: A >>> B[5:0], arithmetic, sign-filled
  - 10 ADDW: sext32(A[31:0] + B[31:0])
  - 11 SUBW: sext32(A[31:0] - B[31:0])
  - 12 NOR: ~(A | B)
  - 13 SLLW: sext32(A[31:0] << B[4:0])
  - 14 SRLW: sext32(A[31:0] >> B[4:0]), logical on 32 bits
  - 15 SRAW: sext32(A[31:0] >>> B[4:0]), arithmetic on 32 bits
- Shift amounts use only B[5:0] (64-bit ops) or B[4:0] (W-ops); upper B bits are ignored, which gives modulo wrap-around. A shift amount of 0 returns A for 64-bit ops and sext32(A[31:0]) for W-ops.
- sext32(x): bit 31 of the 32-bit result is replicated into bits 63:32.
- All 16 codes are defined, so there is no illegal-opcode case and no X propagation for known inputs.
- Reset mid-operation: the pending result is discarded, the outputs go to reset values at once, and no stale result appears after release.

Test Plan:
- Reset: assert rst_n=0 between clock edges -> ALUout=0 and Zero=1 immediately. Release, apply ALUctl=2, A=1560, B=3 -> after 1 clk, ALUout=1563 and Zero=0.
- Logic ops with A=1560, B=3:
  - AND -> 0, Zero=1.
  - OR -> 1563.
  - XOR -> 1563.
  - NOR -> 0xFFFF_FFFF_FFFF_F9E4.
- Arithmetic and compare:
  - SUB A=3, B=1560 -> 0xFFFF_FFFF_FFFF_F9EB.
  - SLT A=1560, B=3 -> 0, Zero=1.
  - SLT A=3, B=1560 -> 1.
  - SLTU A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> 0; SLT with the same operands -> 1.
- Shifts:
  - SLL A=1560, B=3 -> 12480.
  - SRL A=1560, B=3 -> 195.
  - SLL A=3, B=1560 (shamt = 1560 mod 64 = 24) -> 50331648.
  - SRA A=0x8000_0000_0000_0000, B=4 -> 0xF800_0000_0000_0000.
- W-ops:
  - ADDW A=0x7FFF_FFFF, B=1 -> 0xFFFF_FFFF_8000_0000.
  - SUBW A=0, B=1 -> all ones.
  - SRAW A=0x8000_0000, B=1 -> 0xFFFF_FFFF_C000_0000.
  - SRLW with the same operands -> 0x4000_0000.
- Back-to-back: change ALUctl every cycle through codes 0..15 with A/B alternating (1560, 3) and (3, 1560) -> each result appears exactly one cycle later. Zero matches (ALUout == 0) in every cycle.

Source files
------------

// File: rtl/riscv_alu.sv
// riscv_alu: 64-bit RV64I execute-stage integer ALU.
//
// Computes one of 16 operations selected by ALUctl on operands A and B.
// The result and a zero flag are registered, giving one cycle of latency.
// A new operation may start every cycle. The registered Zero flag feeds
// branch resolution in the following cycle.
//
// Ports:
//   clk     in   1   system clock, rising-edge active
//   rst_n   in   1   asynchronous active-low reset (ALUout=0, Zero=1)
//   ALUctl  in   4   operation select
//   A       in  64   operand 1 (rs1)
//   B       in  64   operand 2 (rs2 or immediate)
//   ALUout  out 64   registered result
//   Zero    out  1   registered flag, 1 exactly when ALUout == 0
module riscv_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ALUctl,
    input  logic [63:0] A,
    input  logic [63:0] B,
    output logic [63:0] ALUout,
    output logic        Zero
);

    localparam int DATA_W = 64;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_ADDW = 4'd10;
    localparam logic [3:0] OP_SUBW = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_SLLW = 4'd13;
    localparam logic [3:0] OP_SRLW = 4'd14;
    localparam logic [3:0] OP_SRAW = 4'd15;

    // Replicate bit 31 of a word result into the upper half.
    function automatic logic [DATA_W-1:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [31:0]       a_ws;
    logic [31:0]              addw_w;
    logic [31:0]              subw_w;
    logic [31:0]              sllw_w;
    logic [31:0]              srlw_w;
    logic [31:0]              sraw_w;
    logic [DATA_W-1:0]        result_p0;
    logic                     zero_p0;
    logic [DATA_W-1:0]        result_p1;
    logic                     zero_p1;

    assign a_s  = A;
    assign b_s  = B;
    assign a_ws = A[31:0];

    // Stage p0: combinational result from the current operands
    always_comb begin
        // Word ops are evaluated on 32 bits first so the carry/shift-out
        // never reaches bit 32 before sign extension.
        addw_w = A[31:0] + B[31:0];
        subw_w = A[31:0] - B[31:0];
        sllw_w = A[31:0] << B[4:0];
        srlw_w = A[31:0] >> B[4:0];
        sraw_w = a_ws >>> B[4:0];

        result_p0 = '0;
        case (ALUctl)
            OP_AND:  result_p0 = A & B;
            OP_OR:   result_p0 = A | B;
            OP_ADD:  result_p0 = A + B;
            OP_XOR:  result_p0 = A ^ B;
            OP_SLL:  result_p0 = A << B[5:0];
            OP_SRL:  result_p0 = A >> B[5:0];
            OP_SUB:  result_p0 = A - B;
            OP_SLT:  result_p0 = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: result_p0 = {{(DATA_W-1){1'b0}}, (A < B)};
            OP_SRA:  result_p0 = a_s >>> B[5:0];
            OP_ADDW: result_p0 = sext32(addw_w);
            OP_SUBW: result_p0 = sext32(subw_w);
            OP_NOR:  result_p0 = ~(A | B);
            OP_SLLW: result_p0 = sext32(sllw_w);
            OP_SRLW: result_p0 = sext32(srlw_w);
            OP_SRAW: result_p0 = sext32(sraw_w);
            default: result_p0 = '0;
        endcase

        // Flag derives from the same next-state value so it never lags.
        zero_p0 = (result_p0 == '0);
    end

    // Stage p1: registered result and flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= '0;
            zero_p1   <= 1'b1;
        end else begin
            result_p1 <= result_p0;
            zero_p1   <= zero_p0;
        end
    end

    assign ALUout = result_p1;
    assign Zero   = zero_p1;

endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu: self-checking bench for riscv_alu.
// Stimulus pushes the hand-computed expected result into a queue; a
// monitor pops one entry per clock after the DUT captures and compares
// both ALUout and Zero.
module tb_riscv_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ALUctl;
    logic [63:0] A;
    logic [63:0] B;
    logic [63:0] ALUout;
    logic        Zero;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];

    riscv_alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ALUctl (ALUctl),
        .A      (A),
        .B      (B),
        .ALUout (ALUout),
        .Zero   (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive inputs now and queue the expected result of this operation.
    task automatic drive(input logic [3:0] ctl, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
        ALUctl = ctl;
        A      = a;
        B      = b;
        exp_q.push_back(exp);
    endtask

    task automatic issue(input logic [3:0] ctl, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
        @(negedge clk);
        drive(ctl, a, b, exp);
    endtask

    // Monitor: one result per clock, sampled just after the capture edge.
    always @(posedge clk) begin
        logic [63:0] e;
        #1;
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check64($sformatf("ALUout op=%0d", ALUctl), ALUout, e);
            check1($sformatf("Zero op=%0d", ALUctl), Zero, (e == 64'd0));
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never arrived, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [63:0] bb_exp [16];

    initial begin
        rst_n  = 1'b1;
        ALUctl = 4'd2;
        A      = 64'd5;
        B      = 64'd7;

        // Let the DUT load a nonzero value, then reset between edges.
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check64("reset ALUout async", ALUout, 64'd0);
        check1("reset Zero async", Zero, 1'b1);
        @(posedge clk);
        #1;
        check64("reset ALUout held", ALUout, 64'd0);
        check1("reset Zero held", Zero, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd2, 64'd1560, 64'd3, 64'd1563);

        // Logic ops
        issue(4'd0,  64'd1560, 64'd3, 64'd0);
        issue(4'd1,  64'd1560, 64'd3, 64'd1563);
        issue(4'd3,  64'd1560, 64'd3, 64'd1563);
        issue(4'd12, 64'd1560, 64'd3, 64'hFFFF_FFFF_FFFF_F9E4);
        // Arithmetic and compare
        issue(4'd6,  64'd3, 64'd1560, 64'hFFFF_FFFF_FFFF_F9EB);
        issue(4'd7,  64'd1560, 64'd3, 64'd0);
        issue(4'd7,  64'd3, 64'd1560, 64'd1);
        issue(4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        issue(4'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        // Shifts, including modulo wrap and zero shift amount
        issue(4'd4,  64'd1560, 64'd3, 64'd12480);
        issue(4'd5,  64'd1560, 64'd3, 64'd195);
        issue(4'd4,  64'd3, 64'd1560, 64'd50331648);
        issue(4'd9,  64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
        issue(4'd5,  64'h8000_0000_0000_0001, 64'd64, 64'h8000_0000_0000_0001);
        issue(4'd9,  64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000);
        // Word ops
        issue(4'd10, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
        issue(4'd11, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(4'd15, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_C000_0000);
        issue(4'd14, 64'h8000_0000, 64'd1, 64'h0000_0000_4000_0000);
        issue(4'd13, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000);
        issue(4'd10, 64'hFFFF_FFFF_0000_0005, 64'd0, 64'd5);
        issue(4'd14, 64'hAAAA_AAAA_8000_0000, 64'd32, 64'hFFFF_FFFF_8000_0000);
        drain();

        // Back-to-back through all codes, operands alternating per cycle.
        bb_exp[0]  = 64'd0;
        bb_exp[1]  = 64'd1563;
        bb_exp[2]  = 64'd1563;
        bb_exp[3]  = 64'd1563;
        bb_exp[4]  = 64'd12480;
        bb_exp[5]  = 64'd0;
        bb_exp[6]  = 64'd1557;
        bb_exp[7]  = 64'd1;
        bb_exp[8]  = 64'd0;
        bb_exp[9]  = 64'd0;
        bb_exp[10] = 64'd1563;
        bb_exp[11] = 64'hFFFF_FFFF_FFFF_F9EB;
        bb_exp[12] = 64'hFFFF_FFFF_FFFF_F9E4;
        bb_exp[13] = 64'd50331648;
        bb_exp[14] = 64'd195;
        bb_exp[15] = 64'd0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) issue(4'(i), 64'd1560, 64'd3, bb_exp[i]);
            else            issue(4'(i), 64'd3, 64'd1560, bb_exp[i]);
        end
        drain();

        // Reset while an operation is pending: the result is discarded.
        @(negedge clk);
        ALUctl = 4'd12;
        A      = 64'd1560;
        B      = 64'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check64("midop reset ALUout", ALUout, 64'd0);
        check1("midop reset Zero", Zero, 1'b1);
        @(posedge clk);
        #1;
        check64("midop reset ALUout held", ALUout, 64'd0);
        check1("midop reset Zero held", Zero, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd2, 64'd1560, 64'd3, 64'd1563);
        issue(4'd6, 64'd1560, 64'd1560, 64'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
